// File: rtl/usb_rw_scheduler.sv
// usb_rw_scheduler: round-robin arbiter that serialises host read/write
// requests through the USB read/write FSM, with retry and hang timeout.
module usb_rw_scheduler #(
  parameter int NREQ      = 4,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 1023,
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [16*NREQ-1:0] req_mempage,
  input  logic [64*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic               rsp_ok,
  output logic [63:0]        rsp_rdata,
  output logic [RW-1:0]      rsp_retries,
  output logic               read,
  output logic               write,
  output logic [15:0]        FSMmempage,
  output logic [63:0]        data_from_OS,
  input  logic [63:0]        data_to_host,
  input  logic               isValueReadCorrect,
  input  logic               read_write_FSM_done,
  output logic               busy,
  output logic               timeout_err
);

  localparam int LGW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_GAP,
    S_RESP
  } state_t;

  state_t          state;
  logic [LGW-1:0]  last_grant;
  logic [LGW-1:0]  g_l;
  logic            wr_l;
  logic [RW-1:0]   retry_cnt;
  logic [TW-1:0]   timer;
  logic            cmd_rd;
  logic            cmd_wr;

  logic            hit;
  logic [LGW-1:0]  hit_idx;
  logic [LGW-1:0]  idx;
  logic [15:0]     sel_page;
  logic [63:0]     sel_wdata;
  logic            sel_write;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = LGW'((int'(last_grant) + k) % NREQ);
      if (!hit && req_valid[idx]) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  always_comb begin
    sel_page  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (hit_idx == LGW'(i)) begin
        sel_page  = req_mempage[16*i +: 16];
        sel_wdata = req_wdata[64*i +: 64];
        sel_write = req_write[i];
      end
    end
  end

  // Grant is decided in the IDLE cycle itself so the next grant can land d+2.
  assign req_ready = (state == S_IDLE && hit && !rst) ? (ONE << hit_idx) : '0;

  // Done gating keeps the FSM from re-triggering in its Hold state.
  assign read  = cmd_rd & ~read_write_FSM_done;
  assign write = cmd_wr & ~read_write_FSM_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      last_grant   <= LGW'(NREQ - 1);
      g_l          <= '0;
      wr_l         <= 1'b0;
      retry_cnt    <= '0;
      timer        <= '0;
      cmd_rd       <= 1'b0;
      cmd_wr       <= 1'b0;
      FSMmempage   <= '0;
      data_from_OS <= '0;
      rsp_valid    <= '0;
      rsp_ok       <= 1'b0;
      rsp_rdata    <= '0;
      rsp_retries  <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (hit) begin
            g_l          <= hit_idx;
            wr_l         <= sel_write;
            FSMmempage   <= sel_page;
            data_from_OS <= sel_wdata;
            retry_cnt    <= '0;
            timer        <= '0;
            cmd_rd       <= ~sel_write;
            cmd_wr       <= sel_write;
            busy         <= 1'b1;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (read_write_FSM_done) begin
            cmd_rd <= 1'b0;
            cmd_wr <= 1'b0;
            if (isValueReadCorrect) begin
              rsp_ok      <= 1'b1;
              rsp_rdata   <= wr_l ? 64'd0 : data_to_host;
              rsp_retries <= retry_cnt;
              rsp_valid   <= ONE << g_l;
              state       <= S_RESP;
            end else if (retry_cnt < RW'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 1'b1;
              timer     <= '0;
              state     <= S_GAP;
            end else begin
              rsp_ok      <= 1'b0;
              rsp_rdata   <= '0;
              rsp_retries <= retry_cnt;
              rsp_valid   <= ONE << g_l;
              state       <= S_RESP;
            end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            cmd_rd      <= 1'b0;
            cmd_wr      <= 1'b0;
            timeout_err <= 1'b1;
            rsp_ok      <= 1'b0;
            rsp_rdata   <= '0;
            rsp_retries <= retry_cnt;
            rsp_valid   <= ONE << g_l;
            state       <= S_RESP;
          end
        end
        S_GAP: begin
          cmd_rd <= ~wr_l;
          cmd_wr <= wr_l;
          state  <= S_WAIT;
        end
        S_RESP: begin
          rsp_valid  <= '0;
          last_grant <= g_l;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rw_scheduler.sv
// tb_usb_rw_scheduler: directed scoreboard bench with a behavioural
// read/write FSM model driven from a per-attempt outcome plan.
module tb_usb_rw_scheduler;

  localparam int N = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_write;
  logic [16*N-1:0] req_mempage;
  logic [64*N-1:0] req_wdata;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  rsp_valid;
  logic          rsp_ok;
  logic [63:0]   rsp_rdata;
  logic [1:0]    rsp_retries;
  logic          read;
  logic          write;
  logic [15:0]   FSMmempage;
  logic [63:0]   data_from_OS;
  logic [63:0]   data_to_host;
  logic          isValueReadCorrect;
  logic          read_write_FSM_done;
  logic          busy;
  logic          timeout_err;

  usb_rw_scheduler #(.NREQ(N), .MAX_RETRY(3), .TIMEOUT(1023)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_mempage(req_mempage),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ok(rsp_ok),
    .rsp_rdata(rsp_rdata),
    .rsp_retries(rsp_retries),
    .read(read),
    .write(write),
    .FSMmempage(FSMmempage),
    .data_from_OS(data_from_OS),
    .data_to_host(data_to_host),
    .isValueReadCorrect(isValueReadCorrect),
    .read_write_FSM_done(read_write_FSM_done),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  typedef struct {
    int          idx;
    bit          ok;
    logic [63:0] data;
    int          retries;
  } rsp_t;

  typedef struct {
    int          lat;
    bit          ok;
    bit          hang;
    logic [63:0] data;
  } att_t;

  rsp_t exp_rsp[$];
  int   exp_gnt[$];
  att_t plan[$];

  int n_cmp = 0;
  int n_err = 0;
  int rises = 0;
  int run = 0;
  int last_run = 0;
  bit prev_cmd = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic att_t att(input int lat, input bit ok,
                               input bit hang, input logic [63:0] d);
    att_t a;
    a.lat = lat; a.ok = ok; a.hang = hang; a.data = d;
    return a;
  endfunction

  function automatic rsp_t rsp(input int idx, input bit ok,
                               input logic [63:0] d, input int r);
    rsp_t e;
    e.idx = idx; e.ok = ok; e.data = d; e.retries = r;
    return e;
  endfunction

  // Behavioural FSM: one plan entry per command assertion.
  initial begin
    att_t a;
    read_write_FSM_done = 1'b0;
    isValueReadCorrect  = 1'b0;
    data_to_host        = '0;
    forever begin
      @(posedge clk); #1;
      if ((read | write) && plan.size() > 0) begin
        a = plan.pop_front();
        if (a.hang) begin
          while (read | write) begin
            @(posedge clk); #1;
          end
        end else begin
          repeat (a.lat - 1) begin
            @(posedge clk); #1;
          end
          read_write_FSM_done = 1'b1;
          isValueReadCorrect  = a.ok;
          data_to_host        = a.data;
          @(posedge clk); #1;
          read_write_FSM_done = 1'b0;
          isValueReadCorrect  = 1'b0;
          data_to_host        = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    int g;
    if (req_ready != '0) begin
      if (exp_gnt.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_grant: got %b expected none", req_ready);
      end else begin
        g = exp_gnt.pop_front();
        chk("grant", 64'(req_ready), 64'(4'b0001 << g));
      end
    end
  end

  always @(negedge clk) begin
    rsp_t e;
    if (rsp_valid != '0) begin
      if (exp_rsp.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_rsp: got %b expected none", rsp_valid);
      end else begin
        e = exp_rsp.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << e.idx));
        chk("rsp_ok", 64'(rsp_ok), 64'(e.ok));
        chk("rsp_rdata", rsp_rdata, e.data);
        chk("rsp_retries", 64'(rsp_retries), 64'(e.retries));
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_cmd = 1'b0;
      run = 0;
    end else begin
      if (read | write) begin
        if (!prev_cmd) begin
          rises++;
          run = 0;
        end
        run++;
      end else if (prev_cmd) begin
        last_run = run;
      end
      prev_cmd = read | write;
    end
  end

  task automatic tick();
    logic [N-1:0] g;
    @(negedge clk);
    g = req_ready;
    @(posedge clk); #1;
    req_valid = req_valid & ~g;
  endtask

  task automatic set_req(input int i, input bit w, input logic [15:0] pg,
                         input logic [63:0] wd);
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_mempage[16*i +: 16] = pg;
    req_wdata[64*i +: 64] = wd;
  endtask

  task automatic wait_rsp(input int max);
    int c;
    c = 0;
    while (exp_rsp.size() != 0 && c < max) begin
      tick();
      c++;
    end
    tick();
    if (exp_rsp.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL rsp_timeout: %0d responses outstanding, expected 0",
               exp_rsp.size());
      exp_rsp.delete(); exp_gnt.delete(); plan.delete();
      req_valid = '0;
      rst = 1'b1; tick(); rst = 1'b0; tick();
    end
  endtask

  task automatic wait_cmd(input int max);
    int c;
    c = 0;
    while (!(read | write) && c < max) begin
      tick();
      c++;
    end
  endtask

  initial begin
    int r0;
    rst = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_mempage = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    chk("rst_cmd", 64'({read, write}), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);

    // single read on requester 1
    plan.push_back(att(3, 1, 0, 64'hDEAD_BEEF));
    exp_gnt.push_back(1);
    exp_rsp.push_back(rsp(1, 1, 64'hDEAD_BEEF, 0));
    set_req(1, 0, 16'h00A5, 64'h0);
    wait_cmd(20);
    chk("rd_page", 64'(FSMmempage), 64'h00A5);
    chk("rd_busy", 64'(busy), 64'd1);
    chk("rd_not_write", 64'(write), 64'd0);
    wait_rsp(50);
    chk("rd_held_cycles", 64'(last_run), 64'd2);

    // retry exhaustion on a write
    r0 = rises;
    for (int k = 0; k < 4; k++) plan.push_back(att(2, 0, 0, 64'h77));
    exp_gnt.push_back(2);
    exp_rsp.push_back(rsp(2, 0, 64'h0, 3));
    set_req(2, 1, 16'h0BEE, 64'h0123_4567_89AB_CDEF);
    wait_rsp(100);
    chk("retry_cmd_count", 64'(rises - r0), 64'd4);
    chk("wr_data", data_from_OS, 64'h0123_4567_89AB_CDEF);

    // retry then success
    plan.push_back(att(2, 0, 0, 64'h1));
    plan.push_back(att(2, 1, 0, 64'hCAFE_F00D_0000_0001));
    exp_gnt.push_back(3);
    exp_rsp.push_back(rsp(3, 1, 64'hCAFE_F00D_0000_0001, 1));
    set_req(3, 0, 16'h1234, 64'h0);
    wait_rsp(100);

    // round-robin with requester 0 re-requesting
    for (int k = 0; k < 5; k++) plan.push_back(att(2, 1, 0, 64'h100 + k));
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(2);
    exp_gnt.push_back(3); exp_gnt.push_back(0);
    exp_rsp.push_back(rsp(0, 1, 64'h100, 0));
    exp_rsp.push_back(rsp(1, 1, 64'h0, 0));
    exp_rsp.push_back(rsp(2, 1, 64'h102, 0));
    exp_rsp.push_back(rsp(3, 1, 64'h0, 0));
    exp_rsp.push_back(rsp(0, 1, 64'h104, 0));
    set_req(0, 0, 16'h0010, 64'h0);
    set_req(1, 1, 16'h0011, 64'h11);
    set_req(2, 0, 16'h0012, 64'h0);
    set_req(3, 1, 16'h0013, 64'h33);
    for (int c = 0; c < 20 && req_valid[0]; c++) tick();
    set_req(0, 0, 16'h0020, 64'h0);
    wait_rsp(200);

    // timeout, then normal service resumes
    plan.push_back(att(0, 0, 1, 64'h0));
    exp_gnt.push_back(1);
    exp_rsp.push_back(rsp(1, 0, 64'h0, 0));
    set_req(1, 0, 16'h0F0F, 64'h0);
    wait_rsp(1200);
    chk("to_err_set", 64'(timeout_err), 64'd1);
    chk("to_wait_cycles", 64'(last_run), 64'd1023);
    plan.push_back(att(2, 1, 0, 64'h55));
    exp_gnt.push_back(2);
    exp_rsp.push_back(rsp(2, 1, 64'h55, 0));
    set_req(2, 0, 16'h0002, 64'h0);
    wait_rsp(50);
    chk("to_err_sticky", 64'(timeout_err), 64'd1);

    // reset during WAIT
    plan.push_back(att(0, 0, 1, 64'h0));
    exp_gnt.push_back(3);
    set_req(3, 0, 16'h0003, 64'h0);
    wait_cmd(20);
    rst = 1'b1;
    #1;
    chk("rstw_cmd", 64'({read, write}), 64'd0);
    chk("rstw_busy", 64'(busy), 64'd0);
    chk("rstw_ready", 64'(req_ready), 64'd0);
    chk("rstw_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rstw_timeout_err", 64'(timeout_err), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    plan.push_back(att(2, 1, 0, 64'hA0));
    plan.push_back(att(2, 1, 0, 64'hA3));
    exp_gnt.push_back(0);
    exp_gnt.push_back(3);
    exp_rsp.push_back(rsp(0, 1, 64'hA0, 0));
    exp_rsp.push_back(rsp(3, 1, 64'hA3, 0));
    set_req(0, 0, 16'h0100, 64'h0);
    set_req(3, 0, 16'h0103, 64'h0);
    wait_rsp(100);

    chk("grants_left", 64'(exp_gnt.size()), 64'd0);
    chk("final_idle", 64'(busy), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
